// File: rtl/mult_arbiter.sv
// Round-robin arbiter that gives two requesters access to one shared multiplier.
// It streams the granted operand blocks to the multiplier and routes the result stream back to the owner.
module mult_arbiter #(
  parameter int REGISTER_SIZE  = 32,
  parameter int BITS_IN_NUM    = 2048,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [1:0]                    req_valid_in,
  input  logic [1:0][REGISTER_SIZE-1:0] req_n_in,
  input  logic [1:0][REGISTER_SIZE-1:0] req_m_in,
  output logic [1:0]                    req_ready_out,
  output logic [REGISTER_SIZE-1:0]      mult_n_out,
  output logic [REGISTER_SIZE-1:0]      mult_m_out,
  output logic                          mult_valid_out,
  input  logic                          mult_ready_in,
  input  logic [REGISTER_SIZE-1:0]      mult_data_in,
  input  logic                          mult_valid_in,
  input  logic                          mult_final_in,
  output logic [REGISTER_SIZE-1:0]      resp_data_out,
  output logic                          resp_valid_out,
  output logic                          resp_final_out,
  output logic                          resp_id_out,
  output logic                          busy_out,
  output logic                          timeout_out
);

  localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CNT_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLOCKS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_RESULT} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  blk_cnt_reg, blk_cnt_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              timeout_reg, timeout_next;
  logic              winner;
  logic              in_load;
  logic              in_wait;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      blk_cnt_reg    <= '0;
      wd_reg         <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      blk_cnt_reg    <= blk_cnt_next;
      wd_reg         <= wd_next;
      timeout_reg    <= timeout_next;
    end
  end

  // On a tie the requester that did not win last time is served.
  always_comb begin
    if (req_valid_in == 2'b11) winner = ~last_grant_reg;
    else                       winner = req_valid_in[1];
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    blk_cnt_next    = blk_cnt_reg;
    wd_next         = '0;
    timeout_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        blk_cnt_next = '0;
        if (mult_ready_in && (|req_valid_in)) begin
          grant_next      = winner;
          last_grant_next = winner;
          state_next      = LOAD;
        end
      end
      LOAD: begin
        wd_next = wd_reg + WD_W'(1);
        if (req_valid_in[grant_reg]) begin
          if (blk_cnt_reg == LAST_BLK) begin
            blk_cnt_next = '0;
            state_next   = WAIT_RESULT;
          end else begin
            blk_cnt_next = blk_cnt_reg + CNT_W'(1);
          end
        end
      end
      WAIT_RESULT: begin
        wd_next = wd_reg + WD_W'(1);
        if (mult_final_in) begin
          wd_next    = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Watchdog wins over any other transition in the same cycle.
    if (state_reg != IDLE && wd_reg == WD_LAST) begin
      state_next   = IDLE;
      blk_cnt_next = '0;
      wd_next      = '0;
      timeout_next = 1'b1;
    end
  end

  assign in_load = (state_reg == LOAD);
  assign in_wait = (state_reg == WAIT_RESULT);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready_out[gi] = in_load && (grant_reg == 1'(gi));
  end

  assign mult_valid_out = in_load && req_valid_in[grant_reg];
  assign mult_n_out     = in_load ? req_n_in[grant_reg] : '0;
  assign mult_m_out     = in_load ? req_m_in[grant_reg] : '0;

  assign resp_data_out  = in_wait ? mult_data_in : '0;
  assign resp_valid_out = in_wait && mult_valid_in;
  assign resp_final_out = in_wait && mult_final_in;
  assign resp_id_out    = grant_reg;

  assign busy_out    = (state_reg != IDLE);
  assign timeout_out = timeout_reg;

endmodule
